fifo_rr_ctrl: RTL and testbench
===============================

# fifo_rr_ctrl

Pointer, flag and arbitration controller for a shared synchronous FIFO. Two write requesters share the single write port under round-robin arbitration, and one reader drains it. The block owns the (DEPTH+1)-bit write/read pointers and the full/empty flags, and drives the address/enable/data lines of an external 2^DEPTH-entry storage array. Its wp/rp/full/empty outputs connect directly to the team's FIFO assertion checker.

## Interface
- DEPTH, 2, address bits; storage holds 2^DEPTH entries; pointers are DEPTH+1 bits.
- WIDTH, 8, data width of each write requester.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req0, req1  input  1  write request from requester 0 / 1; held until granted.
- wdata0, wdata1  input  WIDTH  write data from requester 0 / 1; valid while req is high.
- gnt0, gnt1  output  1  write accepted this cycle (combinational); at most one high.
- rd_en  input  1  read request; consumes the entry at mem_raddr.
- mem_we  output  1  storage write enable; equals gnt0 | gnt1.
- mem_waddr  output  DEPTH  wp[DEPTH-1:0].
- mem_wdata  output  WIDTH  wdata of the granted requester; wdata0 when no grant.
- mem_raddr  output  DEPTH  rp[DEPTH-1:0].
- wp, rp  output  DEPTH+1  write / read pointers; MSB is the wrap bit.
- full, empty  output  1  FIFO flags, decoded from registered pointers.
- count  output  DEPTH+1  occupancy, (wp - rp) mod 2^(DEPTH+1), range 0..2^DEPTH.
- ovf, udf  output  1  one-cycle registered pulses for a rejected write / rejected read.

## Operation
- Flags:
  - empty = (wp == rp).
  - full = (wp[DEPTH-1:0] == rp[DEPTH-1:0]) && (wp[DEPTH] != rp[DEPTH]).
  - Both are purely combinational from the pointer registers.
- Arbitration state is a single register, last (0 = requester 0 granted last, 1 = requester 1 granted last). Reset value is 1, so requester 0 wins first.
- Grant rules, when rst is high and full = 0:
  - One requester active: that requester is granted.
  - Both active: grant the requester != last.
  - On any grant, last <= granted index.
  - With no request, or when full, last holds.
- Write: on a grant, wp <= wp + 1, wrapping modulo 2^(DEPTH+1).
- Read: rd_en && !empty -> rp <= rp + 1, wrapping modulo 2^(DEPTH+1).
- Overflow: (req0 | req1) && full -> no grant; ovf = 1 on the next cycle.
- Underflow: rd_en && empty -> rp holds; udf = 1 on the next cycle.
- Simultaneous read and write:
  - Both legal: both pointers advance; count is unchanged.
  - At full: the write is rejected (flags are not look-ahead) and the read proceeds.
  - At empty: the read is rejected and the write proceeds.
- Reset values: wp = rp = 0, last = 1, ovf = udf = 0, so empty = 1, full = 0, count = 0. While rst = 0, gnt0 = gnt1 = mem_we = 0, regardless of req.

## Timing
- Grant latency is 0 cycles: gnt and mem_we are combinational in the request cycle, and the storage captures data at that rising edge.
- Pointers, count, full and empty update on the edge after an accepted operation, so they show new values 1 cycle later.
- ovf/udf assert for exactly one cycle, in the cycle after the rejected request.
- Reset mid-operation clears all state immediately (asynchronously). The first grant is possible in the first cycle with rst high.
- Wrap-around: pointer DEPTH+1 bits all ones -> all zeros with no glitch on the flags.

## Test plan
All scenarios use DEPTH = 2 (4 entries), WIDTH = 8.
- Reset: hold rst = 0 with req0 = req1 = rd_en = 1 -> gnt0 = gnt1 = mem_we = 0, wp = rp = 0, empty = 1, full = 0, count = 0, ovf = udf = 0.
- Fill from requester 0: req0 = 1 for 5 cycles with wdata0 = 0x10..0x14 -> gnt0 high for 4 cycles, mem_waddr 0,1,2,3, wp = 3'b100, full = 1, count = 4. The 5th cycle gives gnt0 = 0 and ovf pulses once.
- Round-robin: from empty, req0 = req1 = 1 continuously, wdata0 = 0xA0, wdata1 = 0xB0 -> grants 0,1,0,1, mem_wdata A0,B0,A0,B0, then no grants with ovf pulsing each cycle.
- Drain: from full, rd_en = 1 for 5 cycles -> mem_raddr 0,1,2,3, rp = 3'b100, empty = 1. The 5th read gives a single udf pulse.
- Wrap and simultaneous access: 6 interleaved single-write/single-read pairs -> wp = rp = 3'b110, empty = 1. Then read and write together at count = 2 -> count stays 2. Read and write together at full -> write rejected, ovf = 1, count = 3.
- Reset mid-fill: assert rst = 0 asynchronously at count = 3 -> wp = rp = 0 and empty = 1 without waiting for a clock edge. After release, req1 alone is granted and last = 1.

Source files
------------

// File: rtl/fifo_rr_ctrl_if.sv
// Write/read handshake and storage-control bundle for the shared FIFO controller.
// master drives requests and data; slave is the controller.
interface fifo_rr_ctrl_if #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic             gnt0;
    logic             gnt1;
    logic             rd_en;
    logic             mem_we;
    logic [DEPTH-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [DEPTH-1:0] mem_raddr;
    logic [DEPTH:0]   wp;
    logic [DEPTH:0]   rp;
    logic             full;
    logic             empty;
    logic [DEPTH:0]   count;
    logic             ovf;
    logic             udf;

    modport master (
        output req0, req1, wdata0, wdata1, rd_en,
        input  gnt0, gnt1, mem_we, mem_waddr, mem_wdata, mem_raddr,
        input  wp, rp, full, empty, count, ovf, udf
    );

    modport slave (
        input  req0, req1, wdata0, wdata1, rd_en,
        output gnt0, gnt1, mem_we, mem_waddr, mem_wdata, mem_raddr,
        output wp, rp, full, empty, count, ovf, udf
    );
endinterface

// File: rtl/fifo_rr_ctrl.sv
// Pointer/flag controller for a shared FIFO with two round-robin write requesters
// and one reader; drives the address/enable/data lines of external storage.
module fifo_rr_ctrl #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    fifo_rr_ctrl_if.slave  bus
);
    localparam int unsigned PW = DEPTH + 1;

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } last_e;

    last_e            last_q, last_d;
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             full_c;
    logic             empty_c;
    logic             gnt0_c;
    logic             gnt1_c;
    logic [WIDTH-1:0] wdata_c;

    // Flags decode straight from the registered pointers; no look-ahead.
    assign empty_c = (wp_q == rp_q);
    assign full_c  = (wp_q[DEPTH-1:0] == rp_q[DEPTH-1:0]) && (wp_q[DEPTH] != rp_q[DEPTH]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= LAST1;
            wp_q   <= '0;
            rp_q   <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    // Arbitration, pointer advance and reject detection; grants gated by reset.
    always_comb begin
        last_d  = last_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        gnt0_c  = 1'b0;
        gnt1_c  = 1'b0;
        wdata_c = bus.wdata0;
        if (rst) begin
            if ((bus.req0 || bus.req1) && full_c) begin
                ovf_d = 1'b1;
            end else if (bus.req0 && (!bus.req1 || last_q == LAST1)) begin
                gnt0_c = 1'b1;
                last_d = LAST0;
            end else if (bus.req1) begin
                gnt1_c  = 1'b1;
                last_d  = LAST1;
                wdata_c = bus.wdata1;
            end
            if (gnt0_c || gnt1_c) begin
                wp_d = wp_q + PW'(1);
            end
            if (bus.rd_en) begin
                if (empty_c) begin
                    udf_d = 1'b1;
                end else begin
                    rp_d = rp_q + PW'(1);
                end
            end
        end
    end

    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.mem_we    = gnt0_c | gnt1_c;
    assign bus.mem_waddr = wp_q[DEPTH-1:0];
    assign bus.mem_wdata = wdata_c;
    assign bus.mem_raddr = rp_q[DEPTH-1:0];
    assign bus.wp        = wp_q;
    assign bus.rp        = rp_q;
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;
    assign bus.count     = wp_q - rp_q;
    assign bus.ovf       = ovf_q;
    assign bus.udf       = udf_q;
endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Scoreboard bench for fifo_rr_ctrl: stimulus queues the expected write-port
// response for each cycle; a negedge monitor pops and compares.
module tb_fifo_rr_ctrl;
    logic clk;
    logic rst;

    fifo_rr_ctrl_if #(.DEPTH(2), .WIDTH(8)) bus ();

    fifo_rr_ctrl #(.DEPTH(2), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         g;
        logic [1:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   passed    = 0;
    int   pend_ovf  = 0;
    int   pend_udf  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic record(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        record(act == exp, name, act, exp);
    endtask

    // One cycle of stimulus; called just after a rising edge.
    task automatic step(input logic r0, input logic r1, input logic rd,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input int g, input logic [1:0] a, input logic [7:0] d,
                        input int eo, input int eu);
        exp_t e;
        bus.req0   = r0;
        bus.req1   = r1;
        bus.rd_en  = rd;
        bus.wdata0 = d0;
        bus.wdata1 = d1;
        e.g    = g;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        pend_ovf += eo;
        pend_udf += eu;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, -1, 2'd0, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.rd_en = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: compares write-port behaviour and reject pulses each cycle.
    always @(negedge clk) begin
        if (rst) begin
            int   act_g;
            exp_t e;
            act_g = (bus.gnt0 && bus.gnt1) ? 2 : bus.gnt0 ? 0 : bus.gnt1 ? 1 : -1;
            if (bus.mem_we != (bus.gnt0 | bus.gnt1)) act_g = 3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                record(act_g == e.g, "grant", act_g, e.g);
                if (e.g >= 0) begin
                    record(bus.mem_waddr == e.addr, "mem_waddr", int'(bus.mem_waddr), int'(e.addr));
                    record(bus.mem_wdata == e.data, "mem_wdata", int'(bus.mem_wdata), int'(e.data));
                end
            end else if (bus.mem_we) begin
                record(1'b0, "unexpected_write", 1, 0);
            end
            if (bus.ovf) begin
                record(pend_ovf > 0, "ovf_pulse", 1, pend_ovf > 0 ? 1 : 0);
                if (pend_ovf > 0) pend_ovf--;
            end
            if (bus.udf) begin
                record(pend_udf > 0, "udf_pulse", 1, pend_udf > 0 ? 1 : 0);
                if (pend_udf > 0) pend_udf--;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        bus.req0   = 1'b1;
        bus.req1   = 1'b1;
        bus.rd_en  = 1'b1;
        bus.wdata0 = 8'h55;
        bus.wdata1 = 8'h66;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt0", int'(bus.gnt0), 0);
        chk("rst_gnt1", int'(bus.gnt1), 0);
        chk("rst_mem_we", int'(bus.mem_we), 0);
        chk("rst_wp", int'(bus.wp), 0);
        chk("rst_rp", int'(bus.rp), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        chk("rst_udf", int'(bus.udf), 0);
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.rd_en = 1'b0;
        rst       = 1'b1;

        // Fill from requester 0; fifth request overflows.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), 8'h00, 0, 2'(i), 8'(8'h10 + i), 0, 0);
        chk("fill_wp", int'(bus.wp), 3'b100);
        chk("fill_full", int'(bus.full), 1);
        chk("fill_count", int'(bus.count), 4);
        step(1'b1, 1'b0, 1'b0, 8'h14, 8'h00, -1, 2'd0, 8'h00, 1, 0);
        chk("fill_ovf", int'(bus.ovf), 1);
        idle();
        chk("fill_ovf_once", int'(bus.ovf), 0);

        // Drain; fifth read underflows.
        for (int i = 0; i < 4; i++) begin
            chk("drain_raddr", int'(bus.mem_raddr), i);
            step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, -1, 2'd0, 8'h00, 0, 0);
        end
        chk("drain_rp", int'(bus.rp), 3'b100);
        chk("drain_empty", int'(bus.empty), 1);
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, -1, 2'd0, 8'h00, 0, 1);
        chk("drain_udf", int'(bus.udf), 1);
        idle();
        chk("drain_udf_once", int'(bus.udf), 0);

        // Round-robin from a fresh reset: 0,1,0,1 then overflow every cycle.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 8'hA0, 8'hB0, 0, 2'd0, 8'hA0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 8'hA0, 8'hB0, 1, 2'd1, 8'hB0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 8'hA0, 8'hB0, 0, 2'd2, 8'hA0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 8'hA0, 8'hB0, 1, 2'd3, 8'hB0, 0, 0);
        chk("rr_full", int'(bus.full), 1);
        chk("rr_count", int'(bus.count), 4);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 8'hA0, 8'hB0, -1, 2'd0, 8'h00, 1, 0);
        chk("rr_ovf", int'(bus.ovf), 1);
        idle();

        // Six write/read pairs move both pointers to 3'b110.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(8'h20 + i), 8'h00, 0, 2'(i), 8'(8'h20 + i), 0, 0);
            step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, -1, 2'd0, 8'h00, 0, 0);
        end
        chk("wrap_wp", int'(bus.wp), 3'b110);
        chk("wrap_rp", int'(bus.rp), 3'b110);
        chk("wrap_empty", int'(bus.empty), 1);
        step(1'b1, 1'b0, 1'b0, 8'h30, 8'h00, 0, 2'd2, 8'h30, 0, 0);
        step(1'b1, 1'b0, 1'b0, 8'h31, 8'h00, 0, 2'd3, 8'h31, 0, 0);
        chk("wrap_wp_zero", int'(bus.wp), 0);
        chk("wrap_count2", int'(bus.count), 2);
        step(1'b1, 1'b0, 1'b1, 8'h32, 8'h00, 0, 2'd0, 8'h32, 0, 0);
        chk("simul_count", int'(bus.count), 2);
        step(1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 0, 2'd1, 8'h33, 0, 0);
        step(1'b1, 1'b0, 1'b0, 8'h34, 8'h00, 0, 2'd2, 8'h34, 0, 0);
        chk("simul_full", int'(bus.full), 1);
        step(1'b1, 1'b0, 1'b1, 8'h35, 8'h00, -1, 2'd0, 8'h00, 1, 0);
        chk("full_rw_ovf", int'(bus.ovf), 1);
        chk("full_rw_count", int'(bus.count), 3);
        idle();
        chk("mid_count3", int'(bus.count), 3);

        // Asynchronous reset mid-cycle, then req1 alone, then both.
        #2 rst = 1'b0;
        #1;
        chk("async_wp", int'(bus.wp), 0);
        chk("async_rp", int'(bus.rp), 0);
        chk("async_empty", int'(bus.empty), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'hC5, 1, 2'd0, 8'hC5, 0, 0);
        step(1'b1, 1'b1, 1'b0, 8'hD0, 8'hD1, 0, 2'd1, 8'hD0, 0, 0);
        idle();

        chk("queue_drained", exp_q.size(), 0);
        chk("ovf_pending", pend_ovf, 0);
        chk("udf_pending", pend_udf, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
